// File: rtl/vga_fetch_arb.sv
// vga_fetch_arb: shared pixel-memory arbiter interleaving per-line prefetch bursts with single writer words.
// Define VGA_ARB_STATS_EN to enable the saturating underrun event counter.
module vga_fetch_arb #(
    parameter int AW       = 19,
    parameter int DW       = 8,
    parameter int H_ACTIVE = 800,
    parameter int BURST    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          line_start,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic          line_busy,
    output logic          underrun,
    output logic [15:0]   underrun_cnt
);
    localparam int WLW = $clog2(H_ACTIVE + 1);
    localparam int BW  = BURST > 1 ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] fetch_ptr_q, fetch_ptr_d;
    logic [WLW-1:0] words_left_q, words_left_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d, pix_data_q, pix_data_d;
    logic          wr_ack_q, wr_ack_d, pix_valid_q, pix_valid_d;
    logic          line_busy_q, line_busy_d, underrun_q, underrun_d;
    logic          fetch_ack, write_ack, burst_end, more;

    always_comb begin
        fetch_ack    = state_q == FETCH && mem_ack;
        write_ack    = state_q == WRITE && mem_ack;
        burst_end    = fetch_ack && (beat_q == BW'(BURST - 1) || words_left_q == WLW'(1));
        words_left_d = line_start ? WLW'(H_ACTIVE) : fetch_ack ? words_left_q - WLW'(1) : words_left_q;
        more         = words_left_d != '0;
        // A restarted line begins where the dropped remainder of the old one would have ended.
        fetch_ptr_d  = frame_start ? '0 :
                       line_start  ? fetch_ptr_q + AW'(words_left_q) :
                       fetch_ack   ? fetch_ptr_q + AW'(1) : fetch_ptr_q;
        beat_d       = burst_end ? '0 : line_start ? BW'(fetch_ack) : fetch_ack ? beat_q + BW'(1) : beat_q;
        state_d      = state_q == IDLE  ? (more ? FETCH : wr_req ? WRITE : IDLE) :
                       state_q == FETCH ? (!burst_end ? FETCH : wr_req ? WRITE : more ? FETCH : IDLE) :
                       (!write_ack ? WRITE : more ? FETCH : IDLE);
        mem_req_d    = state_d != IDLE;
        mem_we_d     = state_d == WRITE;
        mem_addr_d   = state_d == WRITE ? wr_addr : state_d == FETCH ? fetch_ptr_d : mem_addr_q;
        mem_wdata_d  = state_d == WRITE ? wr_data : mem_wdata_q;
        wr_ack_d     = write_ack;
        pix_valid_d  = fetch_ack;
        pix_data_d   = fetch_ack ? mem_rdata : pix_data_q;
        line_busy_d  = line_start || words_left_q != '0;
        underrun_d   = underrun_q || (line_start && line_busy_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_ptr_q  <= '0;
            words_left_q <= '0;
            beat_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wr_ack_q     <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            line_busy_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_ptr_q  <= fetch_ptr_d;
            words_left_q <= words_left_d;
            beat_q       <= beat_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wr_ack_q     <= wr_ack_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            line_busy_q  <= line_busy_d;
            underrun_q   <= underrun_d;
        end
    end

`ifdef VGA_ARB_STATS_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    always_comb underrun_cnt_d = (line_start && line_busy_q && underrun_cnt_q != 16'hFFFF) ?
                                 underrun_cnt_q + 16'd1 : underrun_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) underrun_cnt_q <= '0;
        else underrun_cnt_q <= underrun_cnt_d;
    end

    assign underrun_cnt = underrun_cnt_q;
`else
    assign underrun_cnt = '0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_ack    = wr_ack_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign line_busy = line_busy_q;
    assign underrun  = underrun_q;
endmodule

// File: tb/tb_vga_fetch_arb.sv
// tb_vga_fetch_arb: table-driven line fetches plus stall, underrun and reset sequences for vga_fetch_arb.
module tb_vga_fetch_arb;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int HA = 800;
`ifdef VGA_ARB_STATS_EN
    localparam int EXP_UC = 1;
`else
    localparam int EXP_UC = 0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, line_start = 1'b0;
    logic          wr_req = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack, mem_req, mem_we, pix_valid, line_busy, underrun;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, pix_data;
    logic [15:0]   underrun_cnt;

    vga_fetch_arb dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_start(line_start),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid),
        .line_busy(line_busy), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_of(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    assign mem_rdata = pix_of(mem_addr);

    int total = 0, bad = 0, nprint = 0;
    logic [7:0] sb[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            if (nprint < 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
            nprint++;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_wr_ack"}, wr_ack, 0);
        chk({tag, "_pix_data"}, pix_data, 0);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_line_busy"}, line_busy, 0);
        chk({tag, "_underrun"}, underrun, 0);
        chk({tag, "_underrun_cnt"}, underrun_cnt, 0);
    endtask

    task automatic push_line(input int first, input int n);
        for (int i = 0; i < n; i++) sb.push_back(pix_of(AW'(first + i)));
    endtask

    always @(negedge clk) begin
        if (rst_n && pix_valid) begin
            if (sb.size() == 0) chk("pix_extra", sb.size(), 1);
            else chk("pix_data", pix_data, sb.pop_front());
        end
    end

    typedef struct {
        bit fs;
        bit wr;
        int first;
        int busy;
        int wracks;
        int resume;
    } vec_t;

    vec_t vt[5];

    task automatic run_line(input vec_t v, input int idx);
        int nb = 0, np = 0, nr = 0, nwa = 0, resume = -1, rbw = -1;
        @(negedge clk);
        line_start = 1'b1;
        frame_start = v.fs;
        wr_req = v.wr;
        wr_addr = AW'(32'h71234 + idx);
        wr_data = DW'(8'hA0 + idx);
        push_line(v.first, HA);
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                line_start = 1'b0;
                frame_start = 1'b0;
                chk("first_addr", mem_addr, v.first);
                chk("first_req", mem_req, 1);
            end
            if (line_busy) nb++;
            if (pix_valid) np++;
            if (wr_ack) begin
                nwa++;
                wr_req = 1'b0;
            end
            if (mem_req && mem_we && mem_ack && rbw < 0) begin
                rbw = nr;
                chk("wr_addr", mem_addr, wr_addr);
                chk("wr_data", mem_wdata, wr_data);
            end
            if (mem_req && !mem_we && mem_ack) begin
                if (nr == 16) resume = int'(mem_addr);
                nr++;
            end
            if (!line_busy && !mem_req && !wr_ack) break;
        end
        wr_req = 1'b0;
        chk("busy_cycles", nb, v.busy);
        chk("pix_count", np, HA);
        chk("read_count", nr, HA);
        chk("wr_acks", nwa, v.wracks);
        chk("reads_before_write", rbw, v.wr ? 16 : -1);
        chk("resume_addr", resume, v.resume);
        chk("sb_empty", sb.size(), 0);
        chk("no_underrun", underrun, 0);
    endtask

    initial begin
        int np;
        vt[0] = '{0, 0, 0,    801, 0, 16};
        vt[1] = '{0, 1, 800,  802, 1, 816};
        vt[2] = '{0, 0, 1600, 801, 0, 1616};
        vt[3] = '{1, 0, 0,    801, 0, 16};
        vt[4] = '{0, 1, 800,  802, 1, 816};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        for (int i = 0; i < 5; i++) run_line(vt[i], i);

        // ack stall mid-burst: request and address must hold, no pixels
        @(negedge clk);
        line_start = 1'b1;
        frame_start = 1'b1;
        push_line(0, HA);
        @(negedge clk);
        line_start = 1'b0;
        frame_start = 1'b0;
        repeat (5) @(negedge clk);
        mem_ack = 1'b0;
        chk("stall_addr", mem_addr, 5);
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            chk("stall_req", mem_req, 1);
            chk("stall_addr", mem_addr, 5);
            chk("stall_pix", pix_valid, 0);
        end
        @(negedge clk);
        chk("stall_pix", pix_valid, 0);
        mem_ack = 1'b1;
        for (int c = 0; c < 2000 && line_busy; c++) @(negedge clk);
        chk("stall_done", line_busy, 0);
        chk("stall_sb_empty", sb.size(), 0);

        // second line_start 400 acks into a line
        @(negedge clk);
        line_start = 1'b1;
        frame_start = 1'b1;
        push_line(0, 400);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                line_start = 1'b0;
                frame_start = 1'b0;
            end
        end
        line_start = 1'b1;
        push_line(800, HA);
        @(negedge clk);
        line_start = 1'b0;
        chk("underrun_set", underrun, 1);
        chk("underrun_addr", mem_addr, 800);
        chk("underrun_req", mem_req, 1);
        np = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (pix_valid) np++;
            if (!line_busy) break;
        end
        chk("underrun_pix", np, HA);
        chk("underrun_sb_empty", sb.size(), 0);
        chk("underrun_sticky", underrun, 1);
        chk("underrun_cnt", underrun_cnt, EXP_UC);

        // reset during FETCH, then an immediate writer grant
        @(negedge clk);
        line_start = 1'b1;
        frame_start = 1'b1;
        push_line(0, HA);
        @(negedge clk);
        line_start = 1'b0;
        frame_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_reset_req", mem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        chk_zero("midreset");
        wr_req = 1'b1;
        wr_addr = 19'h05555;
        wr_data = 8'h3C;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_wr_req", mem_req, 1);
        chk("post_wr_we", mem_we, 1);
        chk("post_wr_addr", mem_addr, 19'h05555);
        chk("post_wr_data", mem_wdata, 8'h3C);
        @(negedge clk);
        chk("post_wr_ack", wr_ack, 1);
        wr_req = 1'b0;
        @(negedge clk);
        chk("post_wr_ack_pulse", wr_ack, 0);
        chk("post_wr_idle", mem_req, 0);
        chk("post_busy", line_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
